// File: rtl/dual_rail_scan_responder_pkg.sv
// Shared types for the dual-rail scan responder: handshake FSM states and
// dual-rail pair classification, with pair packed as {rail1, rail0}.
package dual_rail_scan_responder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_DRIVE = 3'd1,
      ST_ACK   = 3'd2,
      ST_RTZ   = 3'd3,
      ST_ERR   = 3'd4
   } state_t;

   localparam logic [1:0] DR_NULL    = 2'b00;
   localparam logic [1:0] DR_VALID0  = 2'b01;
   localparam logic [1:0] DR_VALID1  = 2'b10;
   localparam logic [1:0] DR_ILLEGAL = 2'b11;

   localparam int unsigned N_INPUTS = 7;

   function automatic logic dr_is_valid(input logic [1:0] pair);
      return (pair == DR_VALID0) || (pair == DR_VALID1);
   endfunction

endpackage

// File: rtl/dual_rail_scan_responder_dr_sync2.sv
// Two-flop synchronizer with synchronous active-high reset.
module dr_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic s1_q;
   logic s2_q;

   // metastability filter: two back-to-back flops
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/dual_rail_scan_responder.sv
// Dual-rail 2:1 mux responder with a 4-phase req/ack handshake.
// Define SCAN_RESP_SYNC_EN to put a dr_sync2 on every data/handshake input.
module dual_rail_scan_responder #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in1_0,
   input  logic             in1_1,
   input  logic             in2_0,
   input  logic             in2_1,
   input  logic             sel0,
   input  logic             sel1,
   input  logic             req,
   output logic             q0,
   output logic             q1,
   output logic             ack,
   output logic             err,
   output logic [CNT_W-1:0] xfer_cnt
);

   import dual_rail_scan_responder_pkg::*;

   logic [N_INPUTS-1:0] raw_s;
   logic [N_INPUTS-1:0] smp_s;
   logic [1:0]          p1_s;
   logic [1:0]          p2_s;
   logic [1:0]          ps_s;
   logic                req_s;
   logic                any_ill_s;
   logic                all_valid_s;
   logic                all_null_s;
   logic                ill_watch_s;
   logic                r_d;
   logic [CNT_W-1:0]    cnt_d;

   state_t              state_q;
   logic                q0_q;
   logic                q1_q;
   logic                ack_q;
   logic                err_q;
   logic [CNT_W-1:0]    cnt_q;

   assign raw_s = {req, sel1, sel0, in2_1, in2_0, in1_1, in1_0};

`ifdef SCAN_RESP_SYNC_EN
   for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_sync
      dr_sync2 u_sync (
         .clk (clk),
         .rst (rst),
         .d_i (raw_s[gi]),
         .q_o (smp_s[gi])
      );
   end
`else
   assign smp_s = raw_s;
`endif

   assign p1_s  = smp_s[1:0];
   assign p2_s  = smp_s[3:2];
   assign ps_s  = smp_s[5:4];
   assign req_s = smp_s[6];

   // pair classification and next values for the result bit and counter
   always_comb begin
      any_ill_s   = (p1_s == DR_ILLEGAL) || (p2_s == DR_ILLEGAL) || (ps_s == DR_ILLEGAL);
      all_valid_s = dr_is_valid(p1_s) && dr_is_valid(p2_s) && dr_is_valid(ps_s);
      all_null_s  = (p1_s == DR_NULL) && (p2_s == DR_NULL) && (ps_s == DR_NULL);
      ill_watch_s = (state_q == ST_IDLE) || (state_q == ST_DRIVE) || (state_q == ST_ACK);
      if (ps_s == DR_VALID1) begin
         r_d = (p2_s == DR_VALID1);
      end else begin
         r_d = (p1_s == DR_VALID1);
      end
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   // handshake FSM with registered outputs; ILLEGAL anywhere before RTZ is terminal
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         q0_q    <= 1'b0;
         q1_q    <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= {CNT_W{1'b0}};
      end else if (any_ill_s && ill_watch_s) begin
         state_q <= ST_ERR;
         q0_q    <= 1'b0;
         q1_q    <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_s && all_valid_s) begin
                  state_q <= ST_DRIVE;
                  q1_q    <= r_d;
                  q0_q    <= ~r_d;
               end
            end
            ST_DRIVE: begin
               state_q <= ST_ACK;
               ack_q   <= 1'b1;
            end
            ST_ACK: begin
               if (!req_s && all_null_s) begin
                  state_q <= ST_RTZ;
                  q0_q    <= 1'b0;
                  q1_q    <= 1'b0;
               end
            end
            ST_RTZ: begin
               state_q <= ST_IDLE;
               ack_q   <= 1'b0;
               cnt_q   <= cnt_d;
            end
            ST_ERR: begin
               q0_q  <= 1'b0;
               q1_q  <= 1'b0;
               ack_q <= 1'b0;
               err_q <= 1'b1;
            end
            default: begin
               state_q <= ST_ERR;
               q0_q    <= 1'b0;
               q1_q    <= 1'b0;
               ack_q   <= 1'b0;
               err_q   <= 1'b1;
            end
         endcase
      end
   end

   assign q0       = q0_q;
   assign q1       = q1_q;
   assign ack      = ack_q;
   assign err      = err_q;
   assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_dual_rail_scan_responder.sv
// Scoreboard bench: stimulus schedules expected outputs per cycle, a negedge
// monitor pops and compares. Two DUTs share stimulus (CNT_W=8 and CNT_W=2).
module tb_dual_rail_scan_responder;

`ifdef SCAN_RESP_SYNC_EN
   localparam int L = 2;
`else
   localparam int L = 0;
`endif

   localparam int T_RST = 0, T_STALL = 1, T_Q = 2, T_ACK = 3, T_HOLD = 4;
   localparam int T_RTZ = 5, T_DONE = 6, T_ERR = 7, T_ERRH = 8;

   typedef struct {
      int   cyc;
      logic q1;
      logic q0;
      logic ack;
      logic err;
      int   cnt;
      int   tag;
   } exp_t;

   logic clk, rst;
   logic in1_0, in1_1, in2_0, in2_1, sel0, sel1, req;
   logic q0_a, q1_a, ack_a, err_a;
   logic q0_b, q1_b, ack_b, err_b;
   logic [7:0] cnt_a;
   logic [1:0] cnt_b;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   cnt_m = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   dual_rail_scan_responder #(.CNT_W(8)) u_dut_a (
      .clk(clk), .rst(rst),
      .in1_0(in1_0), .in1_1(in1_1), .in2_0(in2_0), .in2_1(in2_1),
      .sel0(sel0), .sel1(sel1), .req(req),
      .q0(q0_a), .q1(q1_a), .ack(ack_a), .err(err_a), .xfer_cnt(cnt_a)
   );

   dual_rail_scan_responder #(.CNT_W(2)) u_dut_b (
      .clk(clk), .rst(rst),
      .in1_0(in1_0), .in1_1(in1_1), .in2_0(in2_0), .in2_1(in2_1),
      .sel0(sel0), .sel1(sel1), .req(req),
      .q0(q0_b), .q1(q1_b), .ack(ack_b), .err(err_b), .xfer_cnt(cnt_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic string tag_name(input int t);
      case (t)
         T_RST:   return "reset";
         T_STALL: return "null_stall";
         T_Q:     return "q_valid";
         T_ACK:   return "ack_rise";
         T_HOLD:  return "ack_hold";
         T_RTZ:   return "q_null";
         T_DONE:  return "ack_fall_cnt";
         T_ERR:   return "err_entry";
         T_ERRH:  return "err_sticky";
         default: return "unknown";
      endcase
   endfunction

   function automatic logic [1:0] enc(input int v);
      return (v != 0) ? 2'b10 : 2'b01;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input logic [1:0] p1, input logic [1:0] p2, input logic [1:0] ps, input logic rq);
      {in1_1, in1_0} = p1;
      {in2_1, in2_0} = p2;
      {sel1, sel0}   = ps;
      req            = rq;
   endtask

   task automatic push(input int at, input logic [1:0] qv, input logic ackv, input logic errv, input int tag);
      exp_t e;
      e.cyc = at; e.q1 = qv[1]; e.q0 = qv[0]; e.ack = ackv; e.err = errv;
      e.cnt = cnt_m; e.tag = tag;
      exp_q.push_back(e);
   endtask

   // monitor: compare both DUTs against every expectation due this cycle
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         mon_e = exp_q.pop_front();
         checks++;
         if (mon_e.cyc < cyc) begin
            errors++;
            $display("FAIL %s missed: scheduled cyc=%0d seen at cyc=%0d", tag_name(mon_e.tag), mon_e.cyc, cyc);
         end else if ({q1_a, q0_a, ack_a, err_a} !== {mon_e.q1, mon_e.q0, mon_e.ack, mon_e.err}
                      || cnt_a !== 8'(mon_e.cnt)) begin
            errors++;
            $display("FAIL %s cyc=%0d got q1q0=%b%b ack=%b err=%b cnt=%0d expected q1q0=%b%b ack=%b err=%b cnt=%0d",
                     tag_name(mon_e.tag), cyc, q1_a, q0_a, ack_a, err_a, cnt_a,
                     mon_e.q1, mon_e.q0, mon_e.ack, mon_e.err, 8'(mon_e.cnt));
         end
         checks++;
         if ({q1_b, q0_b, ack_b, err_b} !== {mon_e.q1, mon_e.q0, mon_e.ack, mon_e.err}
             || cnt_b !== 2'(mon_e.cnt)) begin
            errors++;
            $display("FAIL %s_w2 cyc=%0d got q1q0=%b%b ack=%b err=%b cnt=%0d expected q1q0=%b%b ack=%b err=%b cnt=%0d",
                     tag_name(mon_e.tag), cyc, q1_b, q0_b, ack_b, err_b, cnt_b,
                     mon_e.q1, mon_e.q0, mon_e.ack, mon_e.err, 2'(mon_e.cnt));
         end
      end
      if (cyc >= 2) begin
         checks++;
         if ((q0_a && q1_a) || (q0_b && q1_b)) begin
            errors++;
            $display("FAIL q_both_high cyc=%0d got a=%b%b b=%b%b expected never 11", cyc, q1_a, q0_a, q1_b, q0_b);
         end
      end
   end

   // one complete handshake; seldly = cycles sel stays NULL after req,
   // split = cycles between req falling and the data going NULL
   task automatic xfer(input int v1, input int v2, input int vs, input int seldly,
                       input int hold, input int split, input bit perturb, input int gap);
      int   c0, a, n;
      logic rv;
      rv = (vs != 0) ? v2[0] : v1[0];
      drive(enc(v1), enc(v2), (seldly > 0) ? 2'b00 : enc(vs), 1'b1);
      c0 = cyc;
      for (int k = 1; k <= seldly; k++) push(c0 + k + L, 2'b00, 1'b0, 1'b0, T_STALL);
      if (seldly > 0) begin
         tick(seldly);
         {sel1, sel0} = enc(vs);
      end
      a = cyc + 1 + L;
      push(a,     {rv, ~rv}, 1'b0, 1'b0, T_Q);
      push(a + 1, {rv, ~rv}, 1'b1, 1'b0, T_ACK);
      tick(2 + L);
      if (perturb) begin
         drive(enc(int'($urandom_range(0, 1))), enc(int'($urandom_range(0, 1))),
               enc(int'($urandom_range(0, 1))), 1'b1);
         tick(1);
      end
      tick(hold);
      if (split > 0) begin
         req = 1'b0;
         tick(split);
      end
      drive(2'b00, 2'b00, 2'b00, 1'b0);
      n = cyc;
      push(n + L,     {rv, ~rv}, 1'b1, 1'b0, T_HOLD);
      push(n + 1 + L, 2'b00,     1'b1, 1'b0, T_RTZ);
      cnt_m++;
      push(n + 2 + L, 2'b00,     1'b0, 1'b0, T_DONE);
      tick(L + 2 + gap);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(2'b00, 2'b00, 2'b00, 1'b0);
      cnt_m = 0;
      push(cyc + 1, 2'b00, 1'b0, 1'b0, T_RST);
      tick(1);
      rst = 1'b0;
      tick(L + 2);
   endtask

   // start a handshake and return once ack is visible
   task automatic start_to_ack(input int v1, input int v2, input int vs);
      int   a;
      logic rv;
      rv = (vs != 0) ? v2[0] : v1[0];
      drive(enc(v1), enc(v2), enc(vs), 1'b1);
      a = cyc + 1 + L;
      push(a,     {rv, ~rv}, 1'b0, 1'b0, T_Q);
      push(a + 1, {rv, ~rv}, 1'b1, 1'b0, T_ACK);
      tick(2 + L);
   endtask

   initial begin
      int c;
      rst = 1'b1;
      drive(2'b00, 2'b00, 2'b00, 1'b0);
      tick(1);
      push(cyc, 2'b00, 1'b0, 1'b0, T_RST);
      tick(1);
      rst = 1'b0;
      tick(L + 2);

      xfer(1, 0, 0, 0, 0, 0, 1'b0, 0);
      xfer(0, 1, 1, 0, 1, 0, 1'b0, 1);
      xfer(1, 0, 1, 0, 0, 0, 1'b0, 0);
      xfer(1, 1, 0, 3, 0, 0, 1'b0, 0);
      xfer(1, 0, 0, 0, 0, 3, 1'b0, 0);

      for (int i = 0; i < 24; i++) begin
         xfer(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
      end

      start_to_ack(0, 1, 1);
      do_reset();

      for (int i = 0; i < 5; i++) begin
         xfer(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
              0, int'($urandom_range(0, 2)), 0, 1'b0, 0);
      end

      drive(enc(1), 2'b11, enc(0), 1'b1);
      c = cyc;
      push(c + 1 + L, 2'b00, 1'b0, 1'b1, T_ERR);
      push(c + 4 + L, 2'b00, 1'b0, 1'b1, T_ERRH);
      tick(1);
      drive(2'b00, 2'b00, 2'b00, 1'b0);
      tick(3 + L);
      do_reset();

      start_to_ack(1, 0, 0);
      {in1_1, in1_0} = 2'b11;
      push(cyc + 1 + L, 2'b00, 1'b0, 1'b1, T_ERR);
      tick(1);
      drive(2'b00, 2'b00, 2'b00, 1'b0);
      tick(L + 3);
      do_reset();

      xfer(0, 0, 1, 0, 0, 0, 1'b0, 0);

      tick(L + 6);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_expectations got %0d left expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dual_rail_scan_responder.md
DUAL_RAIL_SCAN_RESPONDER -- requirements
Module: dual_rail_scan_responder

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the completed-transaction counter.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports in1_0/in1_1  input  1 each  dual-rail data operand 1 (in1_1 = logic 1).
REQ-005 SHALL have ports in2_0/in2_1  input  1 each  dual-rail data operand 2.
REQ-006 SHALL have ports sel0/sel1  input  1 each  dual-rail select (sel1 selects in2).
REQ-007 SHALL have port req  input  1  4-phase request from initiator.
REQ-008 SHALL have ports q0/q1  output  1 each  dual-rail result.
REQ-009 SHALL have port ack  output  1  4-phase acknowledge.
REQ-010 SHALL have port err  output  1  sticky protocol-violation flag.
REQ-011 SHALL have port xfer_cnt  output  CNT_W  completed-transaction count.

Function
REQ-012 SHALL treat a pair as VALID when exactly one rail is 1, NULL when both are 0, ILLEGAL when both are 1.
REQ-013 SHALL implement FSM states IDLE, DRIVE, ACK, RTZ, ERR, all evaluated on sampled inputs.
REQ-014 IDLE: req=1 with all three pairs VALID -> DRIVE, latching the result bit r = sel ? in2 : in1.
REQ-015 IDLE: req=1 with any pair NULL and none ILLEGAL -> remain in IDLE; outputs unchanged.
REQ-016 DRIVE: q1=r, q0=~r for the one cycle spent in DRIVE, then -> ACK; q stays valid through ACK.
REQ-017 ACK: ack=1; input data changes while req=1 are ignored, and the latched r is held.
REQ-018 ACK: req=0 with all three pairs NULL -> RTZ; req=0 with any pair not NULL -> stay in ACK.
REQ-019 RTZ: q0=q1=0 with ack still 1 for one cycle, then ack=0, xfer_cnt+1 (wraps modulo 2^CNT_W), -> IDLE.
REQ-020 Latencies: q valid 1 cycle after the accepting sample; ack rises 1 cycle after q; q nulls 1 cycle after the return-to-zero sample; ack falls 1 cycle after q nulls.
REQ-021 Any ILLEGAL pair sampled in IDLE, DRIVE or ACK -> ERR; ERR drives q0=q1=0, ack=0, err=1 and is left only by rst.
REQ-022 SHALL never drive q0 and q1 high simultaneously in any state.

Reset
REQ-023 rst=1 at a clock edge SHALL force IDLE, q0=q1=0, ack=0, err=0, xfer_cnt=0, synchronizer stages 0.
REQ-024 rst asserted mid-handshake (DRIVE/ACK/RTZ/ERR) SHALL abort; the next transaction starts from IDLE without an increment.

Configuration
REQ-025 Macro SCAN_RESP_SYNC_EN defined: all seven async inputs SHALL pass through 2-flop synchronizers, adding 2 cycles to every input-to-output latency in REQ-020.
REQ-026 Macro SCAN_RESP_SYNC_EN undefined: inputs SHALL be sampled directly (initiator synchronous to clk), with no added latency.

Structure
REQ-027 Shared package SHALL hold the FSM state enum and the dual-rail pair classification constants (NULL, VALID0, VALID1, ILLEGAL).
REQ-028 SHALL instantiate one sub-module, dr_sync2, a 2-flop synchronizer with a synchronous reset, used once per input only under SCAN_RESP_SYNC_EN.

Verification
REQ-029 Case 1: in1=1 (in1_1), in2=0, sel=0 (sel0), req=1 -> q1=1, q0=0, then ack=1; release -> q null, ack=0, xfer_cnt=1.
REQ-030 Case 2: in1=0, in2=1, sel=1 -> q1=1; in1=1, in2=0, sel=1 -> q0=1; check exact cycle latencies per REQ-020 with and without SCAN_RESP_SYNC_EN.
REQ-031 Case 3: req=1 while sel is still NULL, sel0 rises 3 cycles later -> no q/ack until the sel0 sample, then a normal handshake.
REQ-032 Case 4: in2_0=in2_1=1 with req=1 -> err=1, q0=q1=0, ack=0; holds until rst.
REQ-033 Case 5: req falls while in1_1 is still 1 -> ack stays 1 until in1_1=0, then RTZ completes.
REQ-034 Case 6: CNT_W=2, 5 transactions -> xfer_cnt=1; rst during ACK -> all outputs 0 the next cycle, xfer_cnt=0.
